// File: rtl/buf_uart_pkg.sv
// Shared types and default constants for the buffered UART transmitter.
package buf_uart_pkg;

  localparam int CLKS_PER_BIT_DEF = 16;
  localparam int RD_LAT_DEF       = 2;

  typedef logic [7:0] byte_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_START = 3'd3,
    ST_DATA  = 3'd4,
    ST_PAR   = 3'd5,
    ST_STOP  = 3'd6
  } state_t;

endpackage

// File: rtl/buf_uart_baud.sv
// Bit-period timer: counts CLKS_PER_BIT cycles while run is high and
// emits a one-cycle bit_tick on the last cycle of each bit period.
module buf_uart_baud
  import buf_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic CLK,
  input  logic RST,
  input  logic run,
  output logic bit_tick
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  assign bit_tick = run && (cnt == LAST);

  // Counter reloads at every bit boundary and is held at zero between frames
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt <= '0;
    end else if (!run || bit_tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/buf_uart_tx.sv
// Drains bytes from an upstream buffer (REN strobe, RD_LAT read latency)
// and sends each as an 8N1 UART frame on TXD.
// Optional even parity bit: define BUF_UART_TX_PARITY_EN.
module buf_uart_tx
  import buf_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int RD_LAT       = RD_LAT_DEF
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       EN,
  input  logic       EMPTY,
  input  logic [7:0] IN,
  output logic       REN,
  output logic       TXD,
  output logic       BUSY,
  output logic       DONE,
  output logic [7:0] TX_CNT
);

  state_t     state;
  state_t     state_nx;
  byte_t      sr;
  logic [2:0] idx;
  logic [1:0] wcnt;
  logic       bit_tick;
  logic       run;
`ifdef BUF_UART_TX_PARITY_EN
  logic       par;
`endif

  assign run = (state == ST_START) || (state == ST_DATA) ||
               (state == ST_PAR)   || (state == ST_STOP);

  buf_uart_baud #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .CLK     (CLK),
    .RST     (RST),
    .run     (run),
    .bit_tick(bit_tick)
  );

  // Next-state logic; EMPTY and EN only matter when leaving IDLE
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (EN && !EMPTY) state_nx = ST_REQ;
      ST_REQ:   state_nx = ST_WAIT;
      ST_WAIT:  if (wcnt == 2'd0) state_nx = ST_START;
      ST_START: if (bit_tick) state_nx = ST_DATA;
`ifdef BUF_UART_TX_PARITY_EN
      ST_DATA:  if (bit_tick && (idx == 3'd7)) state_nx = ST_PAR;
      ST_PAR:   if (bit_tick) state_nx = ST_STOP;
`else
      ST_DATA:  if (bit_tick && (idx == 3'd7)) state_nx = ST_STOP;
`endif
      ST_STOP:  if (bit_tick) state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Read-latency wait, byte capture, LSB-first shifting and frame counting
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sr     <= '0;
      idx    <= '0;
      wcnt   <= '0;
      TX_CNT <= '0;
`ifdef BUF_UART_TX_PARITY_EN
      par    <= 1'b0;
`endif
    end else begin
      case (state)
        ST_REQ: wcnt <= 2'(RD_LAT - 1);
        ST_WAIT: begin
          if (wcnt == 2'd0) begin
            sr  <= IN;
            idx <= '0;
`ifdef BUF_UART_TX_PARITY_EN
            par <= ^IN;
`endif
          end else begin
            wcnt <= wcnt - 1'b1;
          end
        end
        ST_DATA: begin
          if (bit_tick) begin
            sr  <= {1'b0, sr[7:1]};
            idx <= idx + 1'b1;
          end
        end
        ST_STOP: if (bit_tick) TX_CNT <= TX_CNT + 1'b1;
        default: ;
      endcase
    end
  end

  // Serial line decode; idle, stop and reset all hold the line high
  always_comb begin
    TXD = 1'b1;
    case (state)
      ST_START: TXD = 1'b0;
      ST_DATA:  TXD = sr[0];
`ifdef BUF_UART_TX_PARITY_EN
      ST_PAR:   TXD = par;
`endif
      default:  TXD = 1'b1;
    endcase
  end

  assign REN  = (state == ST_REQ);
  assign BUSY = (state != ST_IDLE);
  assign DONE = (state == ST_STOP) && bit_tick;

endmodule

// File: doc/buf_uart_tx.md
BUF_UART_TX -- requirements
Module: buf_uart_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16, CLK cycles per serial bit, legal range 2..1023.
REQ-002 Parameter RD_LAT, default 2, CLK cycles from the REN pulse to valid IN data from the upstream LIFO/FIFO buffer, legal range 1..3.
REQ-003 CLK  input  1  single clock, all state on the rising edge.
REQ-004 RST  input  1  asynchronous, active-low reset.
REQ-005 EN  input  1  drain enable; high permits new buffer reads.
REQ-006 EMPTY  input  1  upstream buffer holds no data.
REQ-007 IN  input  8  byte from the upstream buffer OUT port.
REQ-008 REN  output  1  read strobe to the upstream buffer.
REQ-009 TXD  output  1  serial line; idles high.
REQ-010 BUSY  output  1  a read or frame is in progress.
REQ-011 DONE  output  1  one-cycle pulse at the end of each frame.
REQ-012 TX_CNT  output  8  count of completed frames; wraps 255->0.

Function
REQ-013 The FSM SHALL use states IDLE, REQ, WAIT, START, DATA, PAR, STOP; in IDLE with EN=1 and EMPTY=0 it SHALL go to REQ.
REQ-014 REQ SHALL last exactly one cycle with REN=1; REN SHALL be 0 in every other state.
REQ-015 WAIT SHALL last RD_LAT cycles, and IN SHALL be captured into an 8-bit shift register on the last WAIT cycle; the FSM then enters START.
REQ-016 START SHALL drive TXD=0 for CLKS_PER_BIT cycles.
REQ-017 DATA SHALL send 8 bits LSB first, each for CLKS_PER_BIT cycles.
REQ-018 PAR SHALL run only when PARITY_EN is defined (REQ-028).
REQ-019 STOP SHALL drive TXD=1 for CLKS_PER_BIT cycles.
REQ-020 On the last STOP cycle the block SHALL pulse DONE for one cycle, increment TX_CNT modulo 256, and return to IDLE.
REQ-021 A frame SHALL be 10*CLKS_PER_BIT cycles long, or 11*CLKS_PER_BIT with parity.
REQ-022 Back-to-back frames: REN SHALL assert at the earliest on the cycle after IDLE is re-entered, giving a gap of RD_LAT+2 cycles of TXD=1 between frames.
REQ-023 BUSY SHALL be 1 in every state except IDLE.
REQ-024 EN falling mid-frame SHALL NOT abort the frame; no further REN SHALL issue until EN=1.
REQ-025 EMPTY SHALL be sampled only in IDLE; EMPTY changes in other states SHALL be ignored.
REQ-026 The bit timer SHALL be a counter of width clog2(CLKS_PER_BIT) that reloads at each bit boundary; the bit index SHALL be a 3-bit counter.

Reset
REQ-027 RST=0 at any time, including mid-frame, SHALL force state IDLE, TXD=1, REN=0, BUSY=0, DONE=0, TX_CNT=0, and clear the shift register and counters; the interrupted byte is lost.

Configuration
REQ-028 Macro BUF_UART_TX_PARITY_EN: when defined, PAR SHALL follow DATA and drive the even-parity bit (XOR of the 8 data bits) for CLKS_PER_BIT cycles; when undefined, DATA SHALL go directly to STOP and no parity logic SHALL exist.

Structure
REQ-029 Package buf_uart_pkg SHALL hold the FSM state enum, a byte typedef, and the default constants for CLKS_PER_BIT and RD_LAT.
REQ-030 A sub-module buf_uart_baud SHALL implement the bit-period timer and emit a one-cycle bit_tick; all other logic SHALL be in buf_uart_tx.

Verification
REQ-031 Reset then idle: RST=0 for 3 cycles, release with EMPTY=1 -> TXD=1, REN=0, BUSY=0, TX_CNT=0 for 50 cycles.
REQ-032 Single byte: CLKS_PER_BIT=4, RD_LAT=2, buffer model returns 8'hA5 -> one REN pulse; TXD = 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles; DONE once; TX_CNT=1.
REQ-033 Parity: PARITY_EN defined, byte 8'h07 -> parity bit 1, frame of 44 cycles; byte 8'h03 -> parity bit 0.
REQ-034 LIFO drain: buffer preloaded 100,150,200 in LIFO mode -> decoded bytes 200,150,100; exactly 3 REN pulses, then idle once EMPTY=1; TX_CNT=3.
REQ-035 EN drop: EN goes to 0 during DATA bit 3 -> the frame completes intact and no REN issues until EN returns to 1.
REQ-036 Reset mid-frame: RST=0 during STOP -> TXD=1 and BUSY=0 immediately; after release, the next byte is sent with a correct full frame and TX_CNT restarts from 0.
